// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and
// load-use hazard detection. Drives the EX-stage ALU operands and opcode.
module id_ex_operand_stage #(
  parameter int WIDTH = 32,
  parameter int RBITS = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [WIDTH-1:0] id_rs_data,
  input  logic [WIDTH-1:0] id_rt_data,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [RBITS-1:0] id_rs,
  input  logic [RBITS-1:0] id_rt,
  input  logic [RBITS-1:0] id_rd,
  input  logic [2:0]       id_alu_op,
  input  logic             id_alu_src,
  input  logic             id_reg_dst,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_mem_to_reg,
  input  logic             flush,
  input  logic             mem_reg_write,
  input  logic [RBITS-1:0] mem_rd,
  input  logic [WIDTH-1:0] mem_alu_res,
  input  logic             wb_reg_write,
  input  logic [RBITS-1:0] wb_rd,
  input  logic [WIDTH-1:0] wb_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic [WIDTH-1:0] ex_store_data,
  output logic [RBITS-1:0] ex_dest,
  output logic             ex_valid,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_mem_to_reg,
  output logic             stall
);

  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ctrl_t;

  logic [WIDTH-1:0] rs_data_q, rt_data_q, imm_q;
  logic [RBITS-1:0] rs_q, rt_q, dest_q;
  logic [2:0]       alu_op_q;
  logic             alu_src_q;
  ctrl_t            ctrl_q;

  logic             bubble;
  logic [WIDTH-1:0] fwd_rs, fwd_rt;

  assign bubble = flush | stall;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      dest_q    <= '0;
      alu_op_q  <= '0;
      alu_src_q <= 1'b0;
      ctrl_q    <= '0;
    end else if (bubble) begin
      // Data fields are don't-care in a bubble; only the control is killed.
      ctrl_q <= '0;
    end else begin
      rs_data_q <= id_rs_data;
      rt_data_q <= id_rt_data;
      imm_q     <= id_imm;
      rs_q      <= id_rs;
      rt_q      <= id_rt;
      dest_q    <= id_reg_dst ? id_rd : id_rt;
      alu_op_q  <= id_alu_op;
      alu_src_q <= id_alu_src;
      ctrl_q    <= '{valid:      id_valid,
                     reg_write:  id_reg_write,
                     mem_read:   id_mem_read,
                     mem_write:  id_mem_write,
                     mem_to_reg: id_mem_to_reg};
    end
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    fwd_rs = rs_data_q;
    if (mem_reg_write && mem_rd != '0 && mem_rd == rs_q)
      fwd_rs = mem_alu_res;
    else if (wb_reg_write && wb_rd != '0 && wb_rd == rs_q)
      fwd_rs = wb_data;

    fwd_rt = rt_data_q;
    if (mem_reg_write && mem_rd != '0 && mem_rd == rt_q)
      fwd_rt = mem_alu_res;
    else if (wb_reg_write && wb_rd != '0 && wb_rd == rt_q)
      fwd_rt = wb_data;
  end

  assign alu_a         = fwd_rs;
  assign alu_b         = alu_src_q ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign alu_op        = alu_op_q;
  assign ex_dest       = dest_q;
  assign ex_valid      = ctrl_q.valid;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;

  // A load in EX feeding the instruction in ID cannot be forwarded in time.
  assign stall = ctrl_q.mem_read && dest_q != '0 &&
                 (dest_q == id_rs || dest_q == id_rt) && id_valid && !flush;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed scenarios plus a
// randomized run against a behavioural pipeline model.
module tb_id_ex_operand_stage;
  localparam int WIDTH = 32;
  localparam int RBITS = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [WIDTH-1:0] id_rs_data, id_rt_data, id_imm;
  logic [RBITS-1:0] id_rs, id_rt, id_rd;
  logic [2:0]       id_alu_op;
  logic             id_alu_src, id_reg_dst;
  logic             id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic             flush;
  logic             mem_reg_write;
  logic [RBITS-1:0] mem_rd;
  logic [WIDTH-1:0] mem_alu_res;
  logic             wb_reg_write;
  logic [RBITS-1:0] wb_rd;
  logic [WIDTH-1:0] wb_data;
  logic [WIDTH-1:0] alu_a, alu_b, ex_store_data;
  logic [2:0]       alu_op;
  logic [RBITS-1:0] ex_dest;
  logic             ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic             stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.WIDTH(WIDTH), .RBITS(RBITS)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_alu_op(id_alu_op), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .flush(flush),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_alu_res(mem_alu_res),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .stall(stall)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; id_alu_op = '0;
    id_alu_src = 0; id_reg_dst = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    flush = 0;
    mem_reg_write = 0; mem_rd = '0; mem_alu_res = '0;
    wb_reg_write = 0; wb_rd = '0; wb_data = '0;
  endtask

  // lw rt, imm(rs): destination is rt
  task automatic drive_load(input logic [RBITS-1:0] rs, input logic [RBITS-1:0] rt);
    idle_inputs();
    id_valid = 1; id_rs = rs; id_rt = rt; id_alu_op = 3'b010; id_alu_src = 1;
    id_imm = 32'h10; id_reg_dst = 0; id_reg_write = 1; id_mem_read = 1; id_mem_to_reg = 1;
  endtask

  task automatic test_reset();
    drive_load(5'd1, 5'd4);
    step();
    total++;
    if (ex_valid !== 1'b1 || ex_mem_read !== 1'b1 || ex_dest !== 5'd4) begin
      bad++;
      $display("FAIL reset_preload: valid=%b mem_read=%b dest=%0d, want 1 1 4",
               ex_valid, ex_mem_read, ex_dest);
    end
    idle_inputs();
    id_valid = 1; id_rs = 5'd4; id_rt = 5'd2;
    #1;
    total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL reset_prestall: stall=%b want 1", stall); end
    #1 rst = 1;
    #1;
    total++;
    if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, stall} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: ctrl/stall=%b want 000000",
               {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, stall});
    end
    total++;
    if (alu_op !== 3'b000 || ex_dest !== '0 || alu_a !== '0 || alu_b !== '0 || ex_store_data !== '0) begin
      bad++;
      $display("FAIL reset_data: op=%0d dest=%0d a=%h b=%h sd=%h want all 0",
               alu_op, ex_dest, alu_a, alu_b, ex_store_data);
    end
    @(negedge clk) rst = 0;
    idle_inputs();
  endtask

  task automatic test_pass_through();
    idle_inputs();
    id_valid = 1; id_rs = 5'd8; id_rs_data = 32'd5; id_rt = 5'd9; id_rt_data = 32'd7;
    id_rd = 5'd10; id_reg_dst = 1; id_alu_op = 3'b010; id_reg_write = 1;
    step();
    total++;
    if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_op !== 3'b010 || ex_dest !== 5'd10) begin
      bad++;
      $display("FAIL pass_add: a=%0d b=%0d op=%b dest=%0d want 5 7 010 10", alu_a, alu_b, alu_op, ex_dest);
    end
    total++;
    if (ex_valid !== 1'b1 || ex_reg_write !== 1'b1 || ex_mem_read !== 1'b0) begin
      bad++;
      $display("FAIL pass_ctrl: valid=%b rw=%b mr=%b want 1 1 0", ex_valid, ex_reg_write, ex_mem_read);
    end
    id_alu_src = 1; id_imm = 32'hFFFF_FFFC;
    step();
    total++;
    if (alu_b !== 32'hFFFF_FFFC || ex_store_data !== 32'd7) begin
      bad++;
      $display("FAIL pass_imm: b=%h sd=%h want fffffffc 00000007", alu_b, ex_store_data);
    end
  endtask

  task automatic test_forward_priority();
    idle_inputs();
    id_valid = 1; id_rs = 5'd3; id_rs_data = 32'h55; id_rt = 5'd12; id_rt_data = 32'h66;
    step();
    mem_reg_write = 1; mem_rd = 5'd3; mem_alu_res = 32'h11;
    wb_reg_write = 1; wb_rd = 5'd3; wb_data = 32'h22;
    #1;
    total++;
    if (alu_a !== 32'h11) begin bad++; $display("FAIL fwd_mem_wins: a=%h want 00000011", alu_a); end
    mem_reg_write = 0;
    #1;
    total++;
    if (alu_a !== 32'h22) begin bad++; $display("FAIL fwd_wb: a=%h want 00000022", alu_a); end
    total++;
    if (alu_b !== 32'h66) begin bad++; $display("FAIL fwd_rt_untouched: b=%h want 00000066", alu_b); end
    idle_inputs();
    id_valid = 1; id_rs = 5'd0; id_rs_data = 32'h77; id_rt = 5'd0; id_rt_data = 32'h88;
    step();
    mem_reg_write = 1; mem_rd = 5'd0; mem_alu_res = 32'h11;
    wb_reg_write = 1; wb_rd = 5'd0; wb_data = 32'h22;
    #1;
    total++;
    if (alu_a !== 32'h77 || alu_b !== 32'h88) begin
      bad++;
      $display("FAIL fwd_zero: a=%h b=%h want 00000077 00000088", alu_a, alu_b);
    end
  endtask

  task automatic test_load_use();
    drive_load(5'd1, 5'd4);
    step();
    idle_inputs();
    id_valid = 1; id_rs = 5'd2; id_rs_data = 32'h3; id_rt = 5'd4; id_rt_data = 32'h0;
    id_rd = 5'd5; id_reg_dst = 1; id_alu_op = 3'b010; id_reg_write = 1;
    #1;
    total++;
    if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall: stall=%b want 1", stall); end
    step();
    total++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 || stall !== 1'b0) begin
      bad++;
      $display("FAIL lu_bubble: valid=%b rw=%b mr=%b stall=%b want 0 0 0 0",
               ex_valid, ex_reg_write, ex_mem_read, stall);
    end
    step();
    wb_reg_write = 1; wb_rd = 5'd4; wb_data = 32'hABCD;
    #1;
    total++;
    if (alu_b !== 32'hABCD || ex_valid !== 1'b1 || ex_dest !== 5'd5 || alu_a !== 32'h3) begin
      bad++;
      $display("FAIL lu_enter: b=%h valid=%b dest=%0d a=%h want 0000abcd 1 5 00000003",
               alu_b, ex_valid, ex_dest, alu_a);
    end
  endtask

  task automatic test_flush_vs_hazard();
    drive_load(5'd1, 5'd4);
    step();
    idle_inputs();
    id_valid = 1; id_rt = 5'd4; id_rd = 5'd5; id_reg_dst = 1;
    id_reg_write = 1; id_mem_write = 1; id_mem_read = 1; id_mem_to_reg = 1;
    flush = 1;
    #1;
    total++;
    if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall: stall=%b want 0", stall); end
    step();
    flush = 0; id_valid = 0;
    #1;
    total++;
    if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} !== 5'b0) begin
      bad++;
      $display("FAIL flush_bubble: ctrl=%b want 00000",
               {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg});
    end
  endtask

  task automatic test_store_data();
    idle_inputs();
    id_valid = 1; id_rs = 5'd0; id_rt = 5'd6; id_rt_data = 32'h5; id_imm = 32'h40;
    id_alu_src = 1; id_alu_op = 3'b010; id_mem_write = 1;
    step();
    mem_reg_write = 1; mem_rd = 5'd6; mem_alu_res = 32'h99;
    #1;
    total++;
    if (alu_b !== 32'h40 || ex_store_data !== 32'h99 || ex_mem_write !== 1'b1) begin
      bad++;
      $display("FAIL store: b=%h sd=%h mw=%b want 00000040 00000099 1", alu_b, ex_store_data, ex_mem_write);
    end
  endtask

  // Model: the instruction currently in EX, as the architecture sees it.
  typedef struct {
    bit              live;     // control bits valid
    bit              known;    // data fields defined (not after a bubble)
    bit              valid, reg_write, mem_read, mem_write, mem_to_reg;
    int unsigned     rs, rt, dest, op;
    bit              use_imm;
    logic [WIDTH-1:0] rs_val, rt_val, imm;
  } ex_instr_t;

  function automatic logic [WIDTH-1:0] operand(input int unsigned idx, input logic [WIDTH-1:0] regval);
    if (idx == 0) return regval;
    if (mem_reg_write && mem_rd == idx) return mem_alu_res;
    if (wb_reg_write && wb_rd == idx) return wb_data;
    return regval;
  endfunction

  task automatic test_random();
    ex_instr_t m;
    logic [WIDTH-1:0] exp_a, exp_b, exp_sd;
    bit exp_stall;
    idle_inputs();
    @(negedge clk) rst = 1;
    @(negedge clk) rst = 0;
    m = '{default: '0};
    m.known = 1;
    for (int i = 0; i < 400; i++) begin
      id_valid = ($urandom_range(0, 9) != 0);
      id_rs = RBITS'($urandom_range(0, 7)); id_rt = RBITS'($urandom_range(0, 7));
      id_rd = RBITS'($urandom_range(0, 7));
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
      id_alu_op = 3'($urandom); id_alu_src = 1'($urandom); id_reg_dst = 1'($urandom);
      id_reg_write = 1'($urandom); id_mem_read = ($urandom_range(0, 2) == 0);
      id_mem_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
      flush = ($urandom_range(0, 9) == 0);
      mem_reg_write = 1'($urandom); mem_rd = RBITS'($urandom_range(0, 7)); mem_alu_res = $urandom;
      wb_reg_write = 1'($urandom); wb_rd = RBITS'($urandom_range(0, 7)); wb_data = $urandom;
      #1;
      exp_stall = m.mem_read && m.dest != 0 && id_valid && !flush &&
                  (m.dest == id_rs || m.dest == id_rt);
      total++;
      if (stall !== exp_stall) begin
        bad++; $display("FAIL rnd_stall[%0d]: got %b want %b", i, stall, exp_stall);
      end
      total++;
      if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg} !==
          {m.valid, m.reg_write, m.mem_read, m.mem_write, m.mem_to_reg}) begin
        bad++;
        $display("FAIL rnd_ctrl[%0d]: got %b want %b", i,
                 {ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
                 {m.valid, m.reg_write, m.mem_read, m.mem_write, m.mem_to_reg});
      end
      if (m.known) begin
        exp_a  = operand(m.rs, m.rs_val);
        exp_sd = operand(m.rt, m.rt_val);
        exp_b  = m.use_imm ? m.imm : exp_sd;
        total++;
        if (alu_a !== exp_a || alu_b !== exp_b || ex_store_data !== exp_sd) begin
          bad++;
          $display("FAIL rnd_data[%0d]: a=%h b=%h sd=%h want %h %h %h",
                   i, alu_a, alu_b, ex_store_data, exp_a, exp_b, exp_sd);
        end
        total++;
        if (alu_op !== 3'(m.op) || ex_dest !== RBITS'(m.dest)) begin
          bad++;
          $display("FAIL rnd_opdest[%0d]: op=%0d dest=%0d want %0d %0d", i, alu_op, ex_dest, m.op, m.dest);
        end
      end
      // Advance the model across the clock edge.
      if (flush || exp_stall) begin
        m.valid = 0; m.reg_write = 0; m.mem_read = 0; m.mem_write = 0; m.mem_to_reg = 0;
        m.known = 0;
      end else begin
        m.known = 1;
        m.valid = id_valid; m.reg_write = id_reg_write; m.mem_read = id_mem_read;
        m.mem_write = id_mem_write; m.mem_to_reg = id_mem_to_reg;
        m.rs = id_rs; m.rt = id_rt; m.dest = id_reg_dst ? id_rd : id_rt;
        m.op = id_alu_op; m.use_imm = id_alu_src;
        m.rs_val = id_rs_data; m.rt_val = id_rt_data; m.imm = id_imm;
      end
      step();
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    test_reset();
    test_pass_through();
    test_forward_priority();
    test_load_use();
    test_flush_vs_hazard();
    test_store_data();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus operand delivery for the EX-stage ALU.
- Latches decoded operands and control from ID each cycle.
- Resolves EX/MEM and MEM/WB data forwarding and drives the ALU's A, B and 3-bit operation inputs.
- Detects load-use hazards, stalls IF/ID and inserts a bubble.

Parameters:
- WIDTH, 32, datapath width
- RBITS, 5, register-index width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs_data  in  WIDTH  register-file rs read value
- id_rt_data  in  WIDTH  register-file rt read value
- id_imm  in  WIDTH  sign-extended immediate
- id_rs, id_rt, id_rd  in  RBITS  source and destination indices
- id_alu_op  in  3  ALU operation code (000 AND, 001 OR, 010 ADD, 011 SUB, 111 SLT)
- id_alu_src  in  1  1 = B operand is immediate
- id_reg_dst  in  1  1 = destination is rd, 0 = rt
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  control bits
- flush  in  1  discard the instruction entering EX (branch taken)
- mem_reg_write  in  1  EX/MEM writes a register
- mem_rd  in  RBITS  EX/MEM destination
- mem_alu_res  in  WIDTH  EX/MEM ALU result
- wb_reg_write  in  1  MEM/WB writes a register
- wb_rd  in  RBITS  MEM/WB destination
- wb_data  in  WIDTH  MEM/WB write-back value
- alu_a, alu_b  out  WIDTH  ALU operands
- alu_op  out  3  registered ALU operation
- ex_store_data  out  WIDTH  forwarded rt value for stores
- ex_dest  out  RBITS  selected destination register
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  registered control
- stall  out  1  hold PC and IF/ID this cycle

Behaviour:
- Registered state: rs_data, rt_data, imm, rs, rt, dest, alu_op, alu_src, valid and four control bits.
- On rst assertion (asynchronous): all registered state clears to 0. Consequences:
  - alu_op = 000, ex_dest = 0, all control outputs = 0.
  - alu_a, alu_b and ex_store_data = 0 unless forwarding fires from live upstream inputs; it cannot fire on the index 0 that rs/rt reset to.
- Register update, each rising edge, in priority order:
  - flush = 1 → bubble.
  - else stall = 1 → bubble.
  - else load the ID inputs, with dest = id_reg_dst ? id_rd : id_rt.
- Bubble: valid, reg_write, mem_read, mem_write and mem_to_reg clear to 0; data fields may hold any value. A bubble never writes a register or memory.
- Latency: ID inputs appear on the EX outputs one cycle after capture.
- Forwarding (combinational on the registered rs/rt):
  - Source S gets mem_alu_res if mem_reg_write && mem_rd != 0 && mem_rd == S.
  - Otherwise wb_data if wb_reg_write && wb_rd != 0 && wb_rd == S.
  - Otherwise the registered value.
  - MEM beats WB when both match. Index 0 is never forwarded.
- alu_a = forwarded rs.
- alu_b = alu_src ? imm : forwarded rt.
- ex_store_data = forwarded rt, whatever alu_src is.
- stall = ex_mem_read && ex_dest != 0 && (ex_dest == id_rs || ex_dest == id_rt) && id_valid && !flush. Combinational. With flush active, stall is 0.
- Load-use: stall is high for exactly one cycle; the bubble then clears ex_mem_read, which drops stall. The held ID instruction enters EX on the following edge, and the loaded value reaches it through WB forwarding.
- Simultaneous flush and hazard: flush wins, and no stall is emitted.
- rst mid-stall: all state clears and stall drops immediately.
- The block performs no arithmetic. Data passes through unmodified; signedness is the consumer's concern.

Test Plan:
- Reset: assert rst mid-cycle with valid state loaded → every output reads 0 immediately (asynchronously); ex_valid = 0; stall = 0.
- Pass-through: ADD with rs=8 (value 5), rt=9 (value 7), alu_src=0, reg_dst=1, rd=10 → next cycle alu_a=5, alu_b=7, alu_op=010, ex_dest=10; with alu_src=1 and imm=0xFFFFFFFC, alu_b=0xFFFFFFFC.
- Forwarding priority: EX rs=3 with mem_rd=3 (0x11) and wb_rd=3 (0x22) both writing → alu_a=0x11; drop mem_reg_write → alu_a=0x22; set rs=0 with mem_rd=0 → alu_a = registered value.
- Load-use: lw to r4 in EX, ID instruction with rt=4 → stall=1 for one cycle; next edge produces a bubble (ex_valid=0, ex_reg_write=0); instruction enters on the following edge; with wb_rd=4, wb_data=0xABCD → alu_b=0xABCD.
- Flush vs hazard: same lw/use condition with flush=1 → stall=0; next cycle all control outputs are 0.
- Store data: sw with alu_src=1, rt=6, mem_rd=6 (0x99) → alu_b=imm, ex_store_data=0x99.
